// File: rtl/md_unit_ctrl_pkg.sv
// Shared pipeline definitions for the multiply/divide unit: op codes, busy
// periods, FSM encoding and the calc result record.
package md_unit_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // wr=0 means the op must leave HI/LO untouched (divide by zero)
  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

endpackage

// File: rtl/md_unit_ctrl_calc.sv
// Combinational multiply/divide datapath for the MD unit.
module md_calc
  import md_unit_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_res_t     res
);

  logic [63:0] prod;
  logic        neg_a, neg_b;
  logic [31:0] ua, ub, uq, ur;

  // Division runs on magnitudes so the INT_MIN / -1 case falls out as 0x80000000
  always_comb begin
    res   = '0;
    prod  = '0;
    neg_a = 1'b0;
    neg_b = 1'b0;
    ua    = '0;
    ub    = '0;
    uq    = '0;
    ur    = '0;
    case (md_op_e'(op))
      MD_MULT: begin
        prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res.wr = 1'b1;
        res.hi = prod[63:32];
        res.lo = prod[31:0];
      end
      MD_MULTU: begin
        prod   = {32'b0, a} * {32'b0, b};
        res.wr = 1'b1;
        res.hi = prod[63:32];
        res.lo = prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b != 32'd0) begin
          neg_a  = (op == MD_DIV) && a[31];
          neg_b  = (op == MD_DIV) && b[31];
          ua     = neg_a ? -a : a;
          ub     = neg_b ? -b : b;
          uq     = ua / ub;
          ur     = ua % ub;
          res.wr = 1'b1;
          res.lo = (neg_a ^ neg_b) ? -uq : uq;
          res.hi = neg_a ? -ur : ur;
        end
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide unit control: IDLE/RUN FSM with a busy down-counter,
// HI/LO architectural registers and the D-stage stall request.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start_E,
  input  logic [2:0]  MDOp_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  input  logic        MDUse_D,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Stop_MD_Out
);

  md_state_e   state;
  logic [3:0]  cnt;
  logic [31:0] hi_tmp, lo_tmp;
  logic        wr_tmp;
  md_res_t     res;

  md_calc u_calc (
    .op  (MDOp_E),
    .a   (A_E),
    .b   (B_E),
    .res (res)
  );

  // Result is captured at start; HI/LO only move on the final busy edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi_tmp <= '0;
      lo_tmp <= '0;
      wr_tmp <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      Busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start_E && is_arith(MDOp_E)) begin
            hi_tmp <= res.hi;
            lo_tmp <= res.lo;
            wr_tmp <= res.wr;
            cnt    <= (MDOp_E == MD_MULT || MDOp_E == MD_MULTU) ? 4'(MULT_CYC) : 4'(DIV_CYC);
            state  <= ST_RUN;
            Busy   <= 1'b1;
          end else if (MDOp_E == MD_MTHI) begin
            HI <= A_E;
          end else if (MDOp_E == MD_MTLO) begin
            LO <= A_E;
          end
        end
        ST_RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (wr_tmp) begin
              HI <= hi_tmp;
              LO <= lo_tmp;
            end
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Stop_MD_Out = MDUse_D & (Busy | (Start_E & is_arith(MDOp_E)));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl with an expected-result scoreboard.
module tb_md_unit_ctrl;
  import md_unit_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start_E;
  logic [2:0]  MDOp_E;
  logic [31:0] A_E, B_E;
  logic        MDUse_D;
  logic        Busy;
  logic [31:0] HI, LO;
  logic        Stop_MD_Out;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  md_unit_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .Start_E     (Start_E),
    .MDOp_E      (MDOp_E),
    .A_E         (A_E),
    .B_E         (B_E),
    .MDUse_D     (MDUse_D),
    .Busy        (Busy),
    .HI          (HI),
    .LO          (LO),
    .Stop_MD_Out (Stop_MD_Out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one arith op; commit=0 models a divide-by-zero that leaves HI/LO as-is.
  // inj >= 0 fires a second start at that busy cycle, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic commit, input logic [31:0] eh,
                        input logic [31:0] el, input int ncyc, input int inj);
    logic [63:0] prev, exp;
    int n;
    @(negedge clk);
    prev = {m_hi, m_lo};
    Start_E = 1'b1; MDOp_E = op; A_E = a; B_E = b;
    if (commit) begin m_hi = eh; m_lo = el; end
    sb_q.push_back({m_hi, m_lo});
    #1;
    if (MDUse_D) chk({tag, "_stop_start"}, 64'(Stop_MD_Out), 64'd1);
    @(negedge clk);
    Start_E = 1'b0; MDOp_E = MD_NONE;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      if (MDUse_D) chk({tag, "_stop_busy"}, 64'(Stop_MD_Out), 64'd1);
      if (n == 0) chk({tag, "_hold"}, {HI, LO}, prev);
      if (n == inj) begin
        Start_E = 1'b1; MDOp_E = MD_MULT; A_E = 32'd3; B_E = 32'd3;
      end else begin
        Start_E = 1'b0; MDOp_E = MD_NONE;
      end
      n++;
      @(negedge clk);
    end
    Start_E = 1'b0; MDOp_E = MD_NONE;
    chk({tag, "_busy_cycles"}, 64'(n), 64'(ncyc));
    exp = sb_q.pop_front();
    chk(tag, {HI, LO}, exp);
    if (MDUse_D) chk({tag, "_stop_after"}, 64'(Stop_MD_Out), 64'd0);
  endtask

  initial begin
    reset = 1'b1; Start_E = 1'b0; MDOp_E = MD_NONE; A_E = '0; B_E = '0; MDUse_D = 1'b0;
    #3;
    chk("rst_hilo", {HI, LO}, 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b0;

    // first op lands on the first edge after reset release
    run_op("mult",  MD_MULT,  32'hFFFFFFFE, 32'd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, -1);
    run_op("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b1, 32'h00000002, 32'hFFFFFFFA, 5, -1);
    run_op("div",   MD_DIV,   32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, -1);
    run_op("divu0", MD_DIVU,  32'd7, 32'd0, 1'b0, 32'd0, 32'd0, 10, -1);
    run_op("divmin", MD_DIV,  32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000, 10, -1);
    run_op("divneg", MD_DIV,  32'd7, 32'hFFFFFFFE, 1'b1, 32'd1, 32'hFFFFFFFD, 10, -1);
    run_op("divu",  MD_DIVU,  32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 10, -1);

    MDUse_D = 1'b1;
    run_op("mult_stall", MD_MULT, 32'd7, 32'd6, 1'b1, 32'd0, 32'd42, 5, 2);
    MDUse_D = 1'b0;

    @(negedge clk);
    MDOp_E = MD_MTHI; A_E = 32'h12345678;
    @(negedge clk);
    MDOp_E = MD_NONE;
    m_hi = 32'h12345678;
    chk("mthi", {HI, LO}, {m_hi, m_lo});
    chk("mthi_busy", 64'(Busy), 64'd0);
    Start_E = 1'b1; MDOp_E = MD_MTLO; A_E = 32'hCAFEBABE;
    @(negedge clk);
    Start_E = 1'b0; MDOp_E = MD_NONE;
    m_lo = 32'hCAFEBABE;
    chk("mtlo", {HI, LO}, {m_hi, m_lo});
    chk("mtlo_busy", 64'(Busy), 64'd0);

    // reset during busy cycle 3 of a div must abort without a later commit
    Start_E = 1'b1; MDOp_E = MD_DIV; A_E = 32'd100; B_E = 32'd3;
    @(negedge clk);
    Start_E = 1'b0; MDOp_E = MD_NONE;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 64'(Busy), 64'd1);
    reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    chk("mid_rst_hilo", {HI, LO}, {m_hi, m_lo});
    chk("mid_rst_busy", 64'(Busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_hilo", {HI, LO}, {m_hi, m_lo});
    chk("post_rst_busy", 64'(Busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
